// File: rtl/bike_pkg.sv
// Shared types and constants for the speed-client divider.
package bike_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic CLIENT_CUR = 1'b0;
    localparam logic CLIENT_AVG = 1'b1;

    localparam int unsigned DIV_WIDTH = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant pointer favours client 0 out of reset.
module rr_arbiter2
    import bike_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic en,
    output logic grant_c,
    output logic grant_valid_c
);

    logic last;

    // On a tie, grant whichever client was not served last.
    always_comb begin
        grant_c       = CLIENT_CUR;
        grant_valid_c = en & (req0 | req1);
        if (req0 && req1) begin
            grant_c = ~last;
        end else if (req1) begin
            grant_c = CLIENT_AVG;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last <= CLIENT_AVG;
        end else if (grant_valid_c) begin
            last <= grant_c;
        end
    end

endmodule

// File: rtl/shared_divider.sv
// Radix-2 restoring unsigned divider shared by the current- and average-speed clients.
module shared_divider
    import bike_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] dividend0,
    input  logic [WIDTH-1:0] divisor0,
    input  logic             req1,
    input  logic [WIDTH-1:0] dividend1,
    input  logic [WIDTH-1:0] divisor1,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             select
);

    state_t state;
    state_t state_next;

    logic             grant_c;
    logic             grant_valid_c;
    logic             arb_en_c;
    logic             accept_c;
    logic             iterate_c;
    logic             finish_c;
    logic             last_iter_c;

    logic [WIDTH-1:0] dvd_in_c;
    logic [WIDTH-1:0] dvs_in_c;
    logic [WIDTH:0]   shifted_c;
    logic             fits_c;
    logic [WIDTH-1:0] diff_c;

    logic [WIDTH-1:0] rem_work;
    logic [WIDTH-1:0] quo_work;
    logic [WIDTH-1:0] dvs_work;
    logic [CNT_W-1:0] cnt;

    rr_arbiter2 u_arb (
        .clk           (clk),
        .rst           (rst),
        .req0          (req0),
        .req1          (req1),
        .en            (arb_en_c),
        .grant_c       (grant_c),
        .grant_valid_c (grant_valid_c)
    );

    assign dvd_in_c    = (grant_c == CLIENT_AVG) ? dividend1 : dividend0;
    assign dvs_in_c    = (grant_c == CLIENT_AVG) ? divisor1  : divisor0;
    assign last_iter_c = (cnt == CNT_W'(WIDTH - 1));

    // One restoring step: the partial remainder always stays below the divisor, so
    // the difference fits in WIDTH bits whenever the trial subtraction succeeds.
    assign shifted_c = {rem_work, quo_work[WIDTH-1]};
    assign fits_c    = (shifted_c >= {1'b0, dvs_work});
    assign diff_c    = shifted_c[WIDTH-1:0] - dvs_work;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid_c) state_next = CALC;
            CALC:    if (last_iter_c) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        arb_en_c  = 1'b0;
        accept_c  = 1'b0;
        iterate_c = 1'b0;
        finish_c  = 1'b0;
        case (state)
            IDLE: begin
                arb_en_c = 1'b1;
                accept_c = grant_valid_c;
            end
            CALC:    iterate_c = 1'b1;
            DONE:    finish_c  = 1'b1;
            default: ;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy        <= 1'b0;
            ready       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            select      <= CLIENT_CUR;
            rem_work    <= '0;
            quo_work    <= '0;
            dvs_work    <= '0;
            cnt         <= '0;
        end else begin
            ready <= 1'b0;
            if (accept_c) begin
                select      <= grant_c;
                busy        <= 1'b1;
                cnt         <= '0;
                div_by_zero <= (dvs_in_c == '0);
                quo_work    <= dvd_in_c;
                dvs_work    <= dvs_in_c;
                rem_work    <= '0;
            end
            if (iterate_c) begin
                cnt      <= cnt + CNT_W'(1);
                rem_work <= fits_c ? diff_c : shifted_c[WIDTH-1:0];
                quo_work <= {quo_work[WIDTH-2:0], fits_c};
            end
            if (finish_c) begin
                quotient  <= quo_work;
                remainder <= rem_work;
                ready     <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end

endmodule
